prirv32_idu: RTL and testbench
==============================

# prirv32_idu

Instruction decode stage for the priRV32 core, placed between the instruction fetch unit and the execute unit. Accepts one fetched instruction per cycle over a valid/ready handshake and reads both source operands from the general register file, with bypass from the same-cycle writeback. Produces a registered decode packet for the execute unit: op class, operands, immediate, destination and branch-prediction tag. Handles load-use stalls and mispredict flushes.

## Interface
- No parameters; XLEN fixed at 32.
- clk_i  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_valid_i  in  1  fetch packet valid
- if_ready_o  out  1  decode accepts packet this cycle
- if_instr_i  in  32  instruction word
- if_pc_i  in  32  instruction address
- if_pred_taken_i  in  1  IFU branch prediction for this instruction
- rf_raddr1_o / rf_raddr2_o  out  5  register file read addresses (combinational from if_instr_i)
- rf_rdata1_i / rf_rdata2_i  in  32  register file read data (combinational)
- wb_we_i, wb_waddr_i[4:0], wb_wdata_i[31:0]  in  writeback port, used for bypass
- ld_busy_i  in  1  execute holds a load whose result is not yet written back
- ld_rd_i  in  5  destination of that load
- flush_i  in  1  mispredict flush from execute
- ex_valid_o  out  1  decode packet valid
- ex_ready_i  in  1  execute accepts packet
- ex_pc_o  out  32; ex_rs1_o, ex_rs2_o  out  32; ex_imm_o  out  32
- ex_rd_o  out  5  destination (0 when instruction has no rd)
- ex_op_o  out  4  op class (package enum)
- ex_funct3_o  out  3; ex_alt_o  out  1  (instr[30])
- ex_pred_taken_o  out  1; ex_illegal_o  out  1

## Operation
- Op classes from opcode[6:0]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALUI, ALU, FENCE, SYSTEM; any other opcode, or instr[1:0] != 2'b11 -> ILLEGAL with ex_illegal_o=1, rd=0.
- Immediate formats I/S/B/U/J, sign-extended from instr[31]; R-type, FENCE, SYSTEM -> imm=0.
- rd forced to 0 for BRANCH, STORE, FENCE, ILLEGAL.
- Operand select per source: if raddr==0 -> 0; else if wb_we_i && wb_waddr_i==raddr -> wb_wdata_i; else rf_rdata.
- Load-use hazard: stall when ld_busy_i && ld_rd_i!=0 && ld_rd_i matches a source the instruction actually uses (rs1 for all but LUI/AUIPC/JAL; rs2 for BRANCH/STORE/ALU).
- Handshake: advance = !(ex_valid_o && !ex_ready_i); if_ready_o = advance && !hazard. Transfer from IFU when if_valid_i && if_ready_o.
- Output register on advance: loads new packet when transfer occurs, else ex_valid_o <= 0 (bubble); stall inserts a bubble.
- Flush: next edge ex_valid_o <= 0; if_ready_o forced 1 during flush and incoming packet dropped. Flush wins over every other event.

## Timing
- Reset: ex_valid_o=0, all ex_* data outputs 0, ex_op_o=ILLEGAL encoding 0? No: all outputs 0, op field 0 (LUI) masked by ex_valid_o=0.
- Latency: fetch transfer at edge N -> ex_valid_o at N+1 with decoded packet.
- Throughput 1/cycle with ex_ready_i held high.
- ex_* held stable while ex_valid_o && !ex_ready_i.
- rf_raddr*_o purely combinational from if_instr_i; no registered path.
- Reset asserted mid-handshake clears ex_valid_o immediately (asynchronous).

## Structure
- Package prirv32_pkg: op-class enum (4 bits), RV32 opcode constants, immediate-format enum.
- Sub-module prirv32_imm_gen: combinational instr -> imm by format. Decode logic, bypass, hazard and pipeline register stay in prirv32_idu.

## Test plan
- ADDI x5,x0,12 (0x00C00293) at pc 0x100 -> next cycle ex_valid_o=1, op ALUI, rd=5, imm=12, rs1=0, ex_pc_o=0x100.
- Same cycle wb_we_i=1, waddr=3, wdata=0xDEADBEEF; decode ADD x1,x3,x3 -> ex_rs1_o=ex_rs2_o=0xDEADBEEF regardless of rf_rdata.
- ld_busy_i=1, ld_rd_i=7; present SW x7,0(x2) -> if_ready_o=0, one bubble (ex_valid_o=0); release ld_busy_i -> accepted next cycle.
- BEQ with offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC, rd=0, op BRANCH; ex_ready_i=0 for 3 cycles -> outputs stable, if_ready_o=0.
- flush_i=1 with if_valid_i=1 and valid packet in output -> if_ready_o=1, next cycle ex_valid_o=0, dropped packet never appears.
- Word 0x00000000 -> ex_illegal_o=1, rd=0; reset asserted during a stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/prirv32_pkg.sv
// Shared decode definitions for the priRV32 core: op classes, RV32 base opcodes
// and immediate formats.
package prirv32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_ALUI    = 4'd7,
        OP_ALU     = 4'd8,
        OP_FENCE   = 4'd9,
        OP_SYSTEM  = 4'd10,
        OP_ILLEGAL = 4'd11
    } op_class_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/prirv32_imm_gen.sv
// Immediate generator: assembles the sign-extended immediate for the selected
// RV32 instruction format; formats without an immediate yield zero.
module prirv32_imm_gen
    import prirv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/prirv32_idu.sv
// priRV32 decode stage: classifies the fetched instruction, reads operands with
// writeback bypass, detects load-use hazards and registers the execute packet.
module prirv32_idu
    import prirv32_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_pred_taken_i,
    output logic [4:0]  rf_raddr1_o,
    output logic [4:0]  rf_raddr2_o,
    input  logic [31:0] rf_rdata1_i,
    input  logic [31:0] rf_rdata2_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        ld_busy_i,
    input  logic [4:0]  ld_rd_i,
    input  logic        flush_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs1_o,
    output logic [31:0] ex_rs2_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rd_o,
    output op_class_e   ex_op_o,
    output logic [2:0]  ex_funct3_o,
    output logic        ex_alt_o,
    output logic        ex_pred_taken_o,
    output logic        ex_illegal_o
);

    op_class_e   op;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rs1_val, rs2_val;
    logic        uses_rs1, uses_rs2;
    logic        hazard, advance, transfer;

    assign rf_raddr1_o = if_instr_i[19:15];
    assign rf_raddr2_o = if_instr_i[24:20];

    always_comb begin
        op  = OP_ILLEGAL;
        fmt = IMM_NONE;
        if (if_instr_i[1:0] == 2'b11) begin
            case (if_instr_i[6:0])
                OPC_LUI:    begin op = OP_LUI;    fmt = IMM_U;    end
                OPC_AUIPC:  begin op = OP_AUIPC;  fmt = IMM_U;    end
                OPC_JAL:    begin op = OP_JAL;    fmt = IMM_J;    end
                OPC_JALR:   begin op = OP_JALR;   fmt = IMM_I;    end
                OPC_BRANCH: begin op = OP_BRANCH; fmt = IMM_B;    end
                OPC_LOAD:   begin op = OP_LOAD;   fmt = IMM_I;    end
                OPC_STORE:  begin op = OP_STORE;  fmt = IMM_S;    end
                OPC_ALUI:   begin op = OP_ALUI;   fmt = IMM_I;    end
                OPC_ALU:    begin op = OP_ALU;    fmt = IMM_NONE; end
                OPC_FENCE:  begin op = OP_FENCE;  fmt = IMM_NONE; end
                OPC_SYSTEM: begin op = OP_SYSTEM; fmt = IMM_NONE; end
                default:    begin op = OP_ILLEGAL; fmt = IMM_NONE; end
            endcase
        end
    end

    prirv32_imm_gen u_imm_gen (
        .instr (if_instr_i[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        case (op)
            OP_BRANCH, OP_STORE, OP_FENCE, OP_ILLEGAL: rd = 5'd0;
            default:                                   rd = if_instr_i[11:7];
        endcase
    end

    // x0 reads as zero; a same-cycle writeback supersedes the stale file value
    function automatic logic [31:0] sel_operand(input logic [4:0] raddr, input logic [31:0] rdata,
                                                input logic we, input logic [4:0] waddr,
                                                input logic [31:0] wdata);
        if (raddr == 5'd0)
            return 32'd0;
        else if (we && (waddr == raddr))
            return wdata;
        else
            return rdata;
    endfunction

    assign rs1_val = sel_operand(rf_raddr1_o, rf_rdata1_i, wb_we_i, wb_waddr_i, wb_wdata_i);
    assign rs2_val = sel_operand(rf_raddr2_o, rf_rdata2_i, wb_we_i, wb_waddr_i, wb_wdata_i);

    assign uses_rs1 = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    assign uses_rs2 = (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_ALU);

    assign hazard = ld_busy_i && (ld_rd_i != 5'd0) &&
                    ((uses_rs1 && (ld_rd_i == rf_raddr1_o)) ||
                     (uses_rs2 && (ld_rd_i == rf_raddr2_o)));

    assign advance    = !(ex_valid_o && !ex_ready_i);
    // during a flush the fetch side is drained: accept and discard
    assign if_ready_o = flush_i || (advance && !hazard);
    assign transfer   = if_valid_i && if_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o      <= 1'b0;
            ex_pc_o         <= '0;
            ex_rs1_o        <= '0;
            ex_rs2_o        <= '0;
            ex_imm_o        <= '0;
            ex_rd_o         <= '0;
            ex_op_o         <= OP_LUI;
            ex_funct3_o     <= '0;
            ex_alt_o        <= 1'b0;
            ex_pred_taken_o <= 1'b0;
            ex_illegal_o    <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (advance) begin
            ex_valid_o <= transfer;
            if (transfer) begin
                ex_pc_o         <= if_pc_i;
                ex_rs1_o        <= rs1_val;
                ex_rs2_o        <= rs2_val;
                ex_imm_o        <= imm;
                ex_rd_o         <= rd;
                ex_op_o         <= op;
                ex_funct3_o     <= if_instr_i[14:12];
                ex_alt_o        <= if_instr_i[30];
                ex_pred_taken_o <= if_pred_taken_i;
                ex_illegal_o    <= (op == OP_ILLEGAL);
            end
        end
    end

endmodule

// File: tb/tb_prirv32_idu.sv
// Self-checking bench for prirv32_idu: directed scenarios plus a randomized run
// against a field-level reference decoder.
module tb_prirv32_idu;
    import prirv32_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        if_valid_i, if_ready_o, if_pred_taken_i;
    logic [31:0] if_instr_i, if_pc_i;
    logic [4:0]  rf_raddr1_o, rf_raddr2_o;
    logic [31:0] rf_rdata1_i, rf_rdata2_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        ld_busy_i;
    logic [4:0]  ld_rd_i;
    logic        flush_i, ex_valid_o, ex_ready_i;
    logic [31:0] ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o;
    logic [4:0]  ex_rd_o;
    op_class_e   ex_op_o;
    logic [2:0]  ex_funct3_o;
    logic        ex_alt_o, ex_pred_taken_o, ex_illegal_o;

    logic [31:0] rf [32];
    int checks = 0;
    int failures = 0;

    assign rf_rdata1_i = rf[rf_raddr1_o];
    assign rf_rdata2_i = rf[rf_raddr2_o];

    always #5 clk_i = ~clk_i;

    prirv32_idu dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_instr_i(if_instr_i),
        .if_pc_i(if_pc_i), .if_pred_taken_i(if_pred_taken_i),
        .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .ld_busy_i(ld_busy_i), .ld_rd_i(ld_rd_i), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_imm_o(ex_imm_o),
        .ex_rd_o(ex_rd_o), .ex_op_o(ex_op_o), .ex_funct3_o(ex_funct3_o), .ex_alt_o(ex_alt_o),
        .ex_pred_taken_o(ex_pred_taken_o), .ex_illegal_o(ex_illegal_o)
    );

    typedef struct {
        op_class_e   op;
        logic [31:0] imm;
        logic [4:0]  rd;
        bit          u1;
        bit          u2;
    } dec_t;

    // Reference decoder built from the instruction-set field layout with integer arithmetic
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   s, t;
        s = $signed(w) >>> 31;
        t = $signed(w) >>> 25;
        d.op = OP_ILLEGAL;
        d.imm = 32'd0;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h37: d.op = OP_LUI;
                7'h17: d.op = OP_AUIPC;
                7'h6F: d.op = OP_JAL;
                7'h67: d.op = OP_JALR;
                7'h63: d.op = OP_BRANCH;
                7'h03: d.op = OP_LOAD;
                7'h23: d.op = OP_STORE;
                7'h13: d.op = OP_ALUI;
                7'h33: d.op = OP_ALU;
                7'h0F: d.op = OP_FENCE;
                7'h73: d.op = OP_SYSTEM;
                default: d.op = OP_ILLEGAL;
            endcase
        end
        case (d.op)
            OP_LUI, OP_AUIPC:           d.imm = w & 32'hFFFFF000;
            OP_JAL:                     d.imm = s * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            OP_JALR, OP_LOAD, OP_ALUI:  d.imm = $signed(w) >>> 20;
            OP_STORE:                   d.imm = t * 32 + int'(w[11:7]);
            OP_BRANCH:                  d.imm = s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            default:                    d.imm = 32'd0;
        endcase
        d.rd = (d.op inside {OP_BRANCH, OP_STORE, OP_FENCE, OP_ILLEGAL}) ? 5'd0 : w[11:7];
        d.u1 = !(d.op inside {OP_LUI, OP_AUIPC, OP_JAL});
        d.u2 = d.op inside {OP_BRANCH, OP_STORE, OP_ALU};
        return d;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_we_i && wb_waddr_i == r) return wb_wdata_i;
        return rf[r];
    endfunction

    task automatic idle();
        if_valid_i = 1'b0; if_instr_i = 32'd0; if_pc_i = 32'd0; if_pred_taken_i = 1'b0;
        wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'd0;
        ld_busy_i = 1'b0; ld_rd_i = 5'd0; flush_i = 1'b0; ex_ready_i = 1'b1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        if_valid_i = 1'b1; if_instr_i = instr; if_pc_i = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #3;
        checks++;
        if ({ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o, ex_rd_o, ex_op_o, ex_funct3_o,
             ex_alt_o, ex_pred_taken_o, ex_illegal_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b pc=%h imm=%h op=%0d expected all zero",
                     ex_valid_o, ex_pc_o, ex_imm_o, ex_op_o);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        @(negedge clk_i);
        drive(32'h00C00293, 32'h100);
        #1;
        checks++;
        if (if_ready_o !== 1'b1 || rf_raddr1_o !== 5'd0) begin
            failures++;
            $display("FAIL addi_accept: ready=%0b raddr1=%0d expected 1/0", if_ready_o, rf_raddr1_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b1 || ex_op_o !== OP_ALUI || ex_rd_o !== 5'd5 || ex_imm_o !== 32'd12 ||
            ex_rs1_o !== 32'd0 || ex_pc_o !== 32'h100) begin
            failures++;
            $display("FAIL addi_packet: v=%0b op=%0d rd=%0d imm=%h rs1=%h pc=%h expected 1/7/5/c/0/100",
                     ex_valid_o, ex_op_o, ex_rd_o, ex_imm_o, ex_rs1_o, ex_pc_o);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk_i);
        rf[3] = 32'h12345678;
        drive(32'h003180B3, 32'h104);
        wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'hDEADBEEF;
        @(posedge clk_i); #1;
        checks++;
        if (ex_rs1_o !== 32'hDEADBEEF || ex_rs2_o !== 32'hDEADBEEF || ex_op_o !== OP_ALU || ex_rd_o !== 5'd1) begin
            failures++;
            $display("FAIL bypass: rs1=%h rs2=%h op=%0d rd=%0d expected deadbeef x2, 8, 1",
                     ex_rs1_o, ex_rs2_o, ex_op_o, ex_rd_o);
        end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_load_use();
        @(negedge clk_i);
        rf[2] = 32'h0000_2000;
        drive(32'h00712023, 32'h108);
        ld_busy_i = 1'b1; ld_rd_i = 5'd7;
        #1;
        checks++;
        if (if_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL load_use_stall: ready=%0b expected 0", if_ready_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL load_use_bubble: valid=%0b expected 0", ex_valid_o);
        end
        @(negedge clk_i);
        ld_busy_i = 1'b0;
        #1;
        checks++;
        if (if_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL load_use_release: ready=%0b expected 1", if_ready_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b1 || ex_op_o !== OP_STORE || ex_rd_o !== 5'd0 || ex_rs1_o !== 32'h2000 ||
            ex_pc_o !== 32'h108 || ex_funct3_o !== 3'd2) begin
            failures++;
            $display("FAIL load_use_accept: v=%0b op=%0d rd=%0d rs1=%h pc=%h f3=%0d expected 1/6/0/2000/108/2",
                     ex_valid_o, ex_op_o, ex_rd_o, ex_rs1_o, ex_pc_o, ex_funct3_o);
        end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_branch_stall();
        @(negedge clk_i);
        drive(32'hFE000EE3, 32'h500);
        if_pred_taken_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b1 || ex_imm_o !== 32'hFFFFFFFC || ex_rd_o !== 5'd0 || ex_op_o !== OP_BRANCH ||
            ex_pred_taken_o !== 1'b1) begin
            failures++;
            $display("FAIL beq_packet: v=%0b imm=%h rd=%0d op=%0d pred=%0b expected 1/fffffffc/0/4/1",
                     ex_valid_o, ex_imm_o, ex_rd_o, ex_op_o, ex_pred_taken_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            ex_ready_i = 1'b0;
            drive(32'h00C00293, 32'h504);
            if_pred_taken_i = 1'b0;
            #1;
            checks++;
            if (if_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_ready[%0d]: ready=%0b expected 0", i, if_ready_o);
            end
            @(posedge clk_i); #1;
            checks++;
            if (ex_valid_o !== 1'b1 || ex_imm_o !== 32'hFFFFFFFC || ex_pc_o !== 32'h500 ||
                ex_op_o !== OP_BRANCH || ex_pred_taken_o !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: v=%0b imm=%h pc=%h op=%0d expected 1/fffffffc/500/4",
                         i, ex_valid_o, ex_imm_o, ex_pc_o, ex_op_o);
            end
        end
        @(negedge clk_i);
        idle();
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_bubble: valid=%0b expected 0", ex_valid_o);
        end
    endtask

    task automatic test_flush();
        @(negedge clk_i);
        drive(32'h00C00293, 32'h200);
        @(negedge clk_i);
        ex_ready_i = 1'b0;
        flush_i = 1'b1;
        drive(32'h003180B3, 32'h300);
        #1;
        checks++;
        if (if_ready_o !== 1'b1 || ex_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready: ready=%0b valid=%0b expected 1/1", if_ready_o, ex_valid_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_kill: valid=%0b expected 0", ex_valid_o);
        end
        @(negedge clk_i);
        idle();
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: valid=%0b pc=%h expected dropped packet absent", ex_valid_o, ex_pc_o);
        end
    endtask

    task automatic test_illegal_reset();
        @(negedge clk_i);
        drive(32'h00000000, 32'h400);
        @(posedge clk_i); #1;
        checks++;
        if (ex_valid_o !== 1'b1 || ex_illegal_o !== 1'b1 || ex_rd_o !== 5'd0 || ex_op_o !== OP_ILLEGAL ||
            ex_pc_o !== 32'h400) begin
            failures++;
            $display("FAIL illegal_packet: v=%0b ill=%0b rd=%0d op=%0d pc=%h expected 1/1/0/11/400",
                     ex_valid_o, ex_illegal_o, ex_rd_o, ex_op_o, ex_pc_o);
        end
        @(negedge clk_i);
        ex_ready_i = 1'b0;
        ld_busy_i = 1'b1; ld_rd_i = 5'd5;
        drive(32'h00128313, 32'h404);
        #1;
        checks++;
        if (if_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_before_reset: ready=%0b expected 0", if_ready_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid_o, ex_pc_o, ex_imm_o, ex_rd_o, ex_op_o, ex_illegal_o} !== '0) begin
            failures++;
            $display("FAIL async_reset: valid=%0b pc=%h ill=%0b op=%0d expected all zero",
                     ex_valid_o, ex_pc_o, ex_illegal_o, ex_op_o);
        end
        @(negedge clk_i);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0]  opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        bit          m_valid = 1'b0;
        logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
        logic [4:0]  m_rd;
        op_class_e   m_op;
        logic [2:0]  m_f3;
        logic        m_alt, m_pred, m_ill;
        dec_t        d;
        logic [31:0] w;
        bit          hz, adv, exp_ready;
        int          k;
        m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0; m_op = OP_LUI;
        m_f3 = 0; m_alt = 0; m_pred = 0; m_ill = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            w = $urandom;
            k = $urandom_range(0, 12);
            if (k < 11) w[6:0] = opcs[k];
            else if (k == 11) w[6:0] = 7'($urandom);
            w[19:18] = 2'b00;
            w[24:23] = 2'b00;
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 7)] = $urandom;
            if_instr_i = w;
            if_pc_i = $urandom;
            if_valid_i = ($urandom_range(0, 3) != 0);
            if_pred_taken_i = 1'($urandom);
            ex_ready_i = ($urandom_range(0, 3) != 0);
            wb_we_i = 1'($urandom);
            wb_waddr_i = 5'($urandom_range(0, 7));
            wb_wdata_i = $urandom;
            ld_busy_i = ($urandom_range(0, 2) == 0);
            ld_rd_i = 5'($urandom_range(0, 7));
            flush_i = ($urandom_range(0, 15) == 0);
            #1;
            d = ref_decode(w);
            hz = ld_busy_i && ld_rd_i != 0 && ((d.u1 && ld_rd_i == w[19:15]) || (d.u2 && ld_rd_i == w[24:20]));
            adv = !(m_valid && !ex_ready_i);
            exp_ready = flush_i || (adv && !hz);
            checks++;
            if (if_ready_o !== exp_ready || rf_raddr1_o !== w[19:15] || rf_raddr2_o !== w[24:20]) begin
                failures++;
                $display("FAIL rand_ready[%0d]: ready=%0b ra1=%0d ra2=%0d expected %0b/%0d/%0d",
                         cyc, if_ready_o, rf_raddr1_o, rf_raddr2_o, exp_ready, w[19:15], w[24:20]);
            end
            if (flush_i) begin
                m_valid = 1'b0;
            end else if (adv) begin
                m_valid = if_valid_i && exp_ready;
                if (m_valid) begin
                    m_pc = if_pc_i; m_rs1 = ref_operand(w[19:15]); m_rs2 = ref_operand(w[24:20]);
                    m_imm = d.imm; m_rd = d.rd; m_op = d.op; m_f3 = w[14:12]; m_alt = w[30];
                    m_pred = if_pred_taken_i; m_ill = (d.op == OP_ILLEGAL);
                end
            end
            @(posedge clk_i); #1;
            checks++;
            if (ex_valid_o !== m_valid) begin
                failures++;
                $display("FAIL rand_valid[%0d]: valid=%0b expected %0b", cyc, ex_valid_o, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (ex_pc_o !== m_pc || ex_rs1_o !== m_rs1 || ex_rs2_o !== m_rs2 || ex_imm_o !== m_imm) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: pc=%h rs1=%h rs2=%h imm=%h expected %h/%h/%h/%h",
                             cyc, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o, m_pc, m_rs1, m_rs2, m_imm);
                end
                checks++;
                if (ex_rd_o !== m_rd || ex_op_o !== m_op || ex_funct3_o !== m_f3 || ex_alt_o !== m_alt ||
                    ex_pred_taken_o !== m_pred || ex_illegal_o !== m_ill) begin
                    failures++;
                    $display("FAIL rand_ctrl[%0d]: rd=%0d op=%0d f3=%0d alt=%0b pred=%0b ill=%0b expected %0d/%0d/%0d/%0b/%0b/%0b",
                             cyc, ex_rd_o, ex_op_o, ex_funct3_o, ex_alt_o, ex_pred_taken_o, ex_illegal_o,
                             m_rd, m_op, m_f3, m_alt, m_pred, m_ill);
                end
            end
        end
        @(negedge clk_i);
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_branch_stall();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
